// File: rtl/mem_bw_token_regulator.sv
// mem_bw_token_regulator
//   Per-master token-bucket regulator. Each master owns an independent signed
//   write (AW) and read (AR) token counter. A shared timer produces a refill
//   tick every refill_period cycles. Every accepted burst debits len+1 beats.
//   A master is allowed while it holds tokens or is granted an override. It
//   requests an override while starved with a request still pending.
//
// Ports
//   aclk, areset                 clock, async active-high reset
//   refill_period                cycles between refill ticks (0 = no refill)
//   token_cap                    positive saturation ceiling for all counters
//   aw_refill_amt, ar_refill_amt per-master refill amount per tick
//   aw_hs, ar_hs                 per-master accepted-handshake pulses
//   aw_len, ar_len               per-master AXI len sampled with the handshake
//   aw_pending, ar_pending       per-master blocked-request indication
//   aw_overrides, ar_overrides   per-master override grants
//   aw_allow, ar_allow           per-master channel gates
//   aw_can_override, ar_can_override  per-master override requests
module mem_bw_token_regulator #(
  parameter int NUM_MASTERS  = 4,
  parameter int TOKEN_WIDTH  = 12,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [PERIOD_WIDTH-1:0]                refill_period,
  input  logic [TOKEN_WIDTH-2:0]                 token_cap,
  input  logic [NUM_MASTERS*(TOKEN_WIDTH-1)-1:0] aw_refill_amt,
  input  logic [NUM_MASTERS*(TOKEN_WIDTH-1)-1:0] ar_refill_amt,
  input  logic [NUM_MASTERS-1:0]                 aw_hs,
  input  logic [NUM_MASTERS-1:0]                 ar_hs,
  input  logic [NUM_MASTERS*8-1:0]               aw_len,
  input  logic [NUM_MASTERS*8-1:0]               ar_len,
  input  logic [NUM_MASTERS-1:0]                 aw_pending,
  input  logic [NUM_MASTERS-1:0]                 ar_pending,
  input  logic [NUM_MASTERS-1:0]                 aw_overrides,
  input  logic [NUM_MASTERS-1:0]                 ar_overrides,
  output logic [NUM_MASTERS-1:0]                 aw_allow,
  output logic [NUM_MASTERS-1:0]                 ar_allow,
  output logic [NUM_MASTERS-1:0]                 aw_can_override,
  output logic [NUM_MASTERS-1:0]                 ar_can_override
);

  localparam int AMT_WIDTH = TOKEN_WIDTH - 1;
  // Two guard bits cover the largest credit plus the largest debit without wrap.
  localparam int EXT_WIDTH = TOKEN_WIDTH + 2;
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
  localparam logic signed [TOKEN_WIDTH-1:0] TOK_ZERO = '0;

  logic                          loaded;
  logic [PERIOD_WIDTH-1:0]       period_cnt;
  logic [PERIOD_WIDTH-1:0]       period_last;
  logic                          tick;
  logic signed [TOKEN_WIDTH-1:0] cap_tok;
  logic signed [TOKEN_WIDTH-1:0] aw_tok [NUM_MASTERS];
  logic signed [TOKEN_WIDTH-1:0] ar_tok [NUM_MASTERS];

  assign cap_tok     = {1'b0, token_cap};
  assign period_last = refill_period - PERIOD_ONE;

  // The >= compare (not ==) makes a shrunken period fire on the next cycle
  // instead of waiting for the counter to wrap through 2^PERIOD_WIDTH.
  assign tick = loaded && (refill_period != '0) && (period_cnt >= period_last);

  // loaded marks the first edge after reset as the load edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      loaded <= 1'b0;
    end else begin
      loaded <= 1'b1;
    end
  end

  // The timer stays at 0 through the load edge and begins counting on it, so the
  // first tick lands refill_period cycles after load.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      period_cnt <= '0;
    end else if (!loaded || (refill_period == '0) || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_ONE;
    end
  end

  function automatic logic signed [TOKEN_WIDTH-1:0] next_tok(
    input logic signed [TOKEN_WIDTH-1:0] tok,
    input logic                          tick_i,
    input logic [AMT_WIDTH-1:0]          amt,
    input logic                          hs,
    input logic [7:0]                    len,
    input logic [AMT_WIDTH-1:0]          cap
  );
    logic signed [EXT_WIDTH-1:0]   tok_x;
    logic signed [EXT_WIDTH-1:0]   credit;
    logic signed [EXT_WIDTH-1:0]   debit;
    logic signed [EXT_WIDTH-1:0]   sum;
    logic signed [EXT_WIDTH-1:0]   cap_x;
    logic signed [EXT_WIDTH-1:0]   min_x;
    logic [8:0]                    beats;
    logic signed [TOKEN_WIDTH-1:0] result;
    beats  = {1'b0, len} + 9'd1;
    tok_x  = {{(EXT_WIDTH-TOKEN_WIDTH){tok[TOKEN_WIDTH-1]}}, tok};
    credit = tick_i ? {{(EXT_WIDTH-AMT_WIDTH){1'b0}}, amt} : '0;
    debit  = hs ? {{(EXT_WIDTH-9){1'b0}}, beats} : '0;
    cap_x  = {{(EXT_WIDTH-AMT_WIDTH){1'b0}}, cap};
    min_x  = {{(EXT_WIDTH-AMT_WIDTH){1'b1}}, {AMT_WIDTH{1'b0}}};
    sum    = tok_x + credit - debit;
    if (sum > cap_x) begin
      result = cap_x[TOKEN_WIDTH-1:0];
    end else if (sum < min_x) begin
      result = min_x[TOKEN_WIDTH-1:0];
    end else begin
      result = sum[TOKEN_WIDTH-1:0];
    end
    return result;
  endfunction

  // Overrides never touch the counters; an overridden burst is debited like
  // any other and pushes the master into debt.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        aw_tok[j] <= '0;
        ar_tok[j] <= '0;
      end
    end else if (!loaded) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        aw_tok[j] <= cap_tok;
        ar_tok[j] <= cap_tok;
      end
    end else begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        aw_tok[j] <= next_tok(aw_tok[j], tick, aw_refill_amt[j*AMT_WIDTH +: AMT_WIDTH],
                              aw_hs[j], aw_len[j*8 +: 8], token_cap);
        ar_tok[j] <= next_tok(ar_tok[j], tick, ar_refill_amt[j*AMT_WIDTH +: AMT_WIDTH],
                              ar_hs[j], ar_len[j*8 +: 8], token_cap);
      end
    end
  end

  always_comb begin
    aw_allow        = '0;
    ar_allow        = '0;
    aw_can_override = '0;
    ar_can_override = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      aw_allow[j]        = loaded & ((aw_tok[j] > TOK_ZERO) | aw_overrides[j]);
      ar_allow[j]        = loaded & ((ar_tok[j] > TOK_ZERO) | ar_overrides[j]);
      aw_can_override[j] = loaded & (aw_tok[j] <= TOK_ZERO) & aw_pending[j];
      ar_can_override[j] = loaded & (ar_tok[j] <= TOK_ZERO) & ar_pending[j];
    end
  end

endmodule

// File: doc/mem_bw_token_regulator.md
# mem_bw_token_regulator

Per-master token-bucket regulator for memory bandwidth isolation; it sits between the per-master AXI4 throttles and the override arbiter in the memory bandwidth throttler. For each master it keeps separate signed write (AW) and read (AR) token counters. Each counter is refilled periodically and debited by the beat count of every accepted burst. The block drives the per-master `*_allow` gates, and it raises `*_can_override` requests whenever a master is starved but still has a request pending.

## Interface
Parameters:
- `NUM_MASTERS`, 4, number of regulated AXI4 masters.
- `TOKEN_WIDTH`, 12, width of each signed token counter; must be ≥ 10.
- `PERIOD_WIDTH`, 16, width of the refill period counter.

Ports:
- `aclk`  in  1  clock; all logic is on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `refill_period`  in  PERIOD_WIDTH  cycles between refill ticks; 0 disables refills.
- `token_cap`  in  TOKEN_WIDTH-1  positive saturation ceiling shared by all counters.
- `aw_refill_amt`, `ar_refill_amt`  in  NUM_MASTERS*TOKEN_WIDTH-1  per-master unsigned refill amount per tick.
- `aw_hs`, `ar_hs`  in  NUM_MASTERS  one-cycle pulse per accepted AW/AR handshake.
- `aw_len`, `ar_len`  in  NUM_MASTERS*8  AXI len of the handshaked burst, sampled with `*_hs`.
- `aw_pending`, `ar_pending`  in  NUM_MASTERS  master's address valid is asserted but currently blocked.
- `aw_overrides`, `ar_overrides`  in  NUM_MASTERS  override grants from the override arbiter.
- `aw_allow`, `ar_allow`  out  NUM_MASTERS  channel gate to the throttle.
- `aw_can_override`, `ar_can_override`  out  NUM_MASTERS  override request to the arbiter.

## Operation
- **Refill timer.**
  - A single PERIOD_WIDTH counter counts up each cycle while `refill_period` ≠ 0.
  - When count ≥ `refill_period`-1, the counter produces a one-cycle `tick` and wraps to 0.
  - Shrinking `refill_period` below the current count forces a tick on the next cycle.
  - `refill_period` = 0 holds the count at 0 and suppresses all ticks.
- **Counter update.** Each counter `tok` (signed, TOKEN_WIDTH) updates every cycle as: next = `tok` + (`tick` ? amt : 0) − (`hs` ? `len`+1 : 0).
  - Compute this in TOKEN_WIDTH+2 bits.
  - Saturate high at `token_cap`.
  - Saturate low at −2^(TOKEN_WIDTH-1).
  - A simultaneous tick and handshake apply both terms in the same cycle.
- **Overrides.** An overridden burst is still debited, so the counter goes into debt; overrides never modify counters directly.
- **Outputs (combinational from registered state).**
  - `allow[j]` = `loaded` & ((`tok[j]` > 0) | `overrides[j]`).
  - `can_override[j]` = `loaded` & (`tok[j]` ≤ 0) & `pending[j]`.
- **Reset and load.**
  - Reset clears all counters, the period counter and the `loaded` flag to 0.
  - On the first clock edge after `areset` deasserts, every counter loads `token_cap` and `loaded` sets; the timer starts on that same edge.
  - `tick` and `hs` in that load cycle are ignored.
- **Channel independence.** AW and AR counters are fully independent, and so are the counters of different masters.
- **Reset mid-operation.** Asserting `areset` asynchronously returns the block to the reset state, and all outputs drop to 0 immediately.

## Timing
- Reset value of every output is 0.
- A `*_hs` at edge n debits the counter at edge n+1. The resulting `allow`/`can_override` change is visible after edge n+1, a 1-cycle latency.
- A `tick` generated in cycle n credits counters at edge n+1.
- `*_overrides` → `*_allow` is combinational, 0 cycles.
- Throughput: one handshake per master per channel per cycle is accepted with no back-pressure.
- Refill period in cycles equals `refill_period` exactly; the first tick occurs `refill_period` cycles after the load edge.

## Test plan
- **Reset/load.** Assert `areset` with `token_cap`=100 → all outputs 0 during reset. One cycle after release, `aw_allow`=`ar_allow`=all 1 and `can_override`=0.
- **Debit to starvation.** Set `token_cap`=100 and `refill_period`=0. Send four `aw_hs[0]` with `aw_len`=31 (4×32=128 beats) → counter reads −28. `aw_allow[0]`=0 from the cycle after the 4th handshake; other masters and AR are unaffected.
- **Refill and saturation.** Set `refill_period`=10 and `ar_refill_amt[1]`=40 with no traffic → `ar` tokens of master 1 stay at `token_cap`=100. After debiting to −28, three ticks give −28→12→52→92 and the fourth tick saturates at 100; ticks occur every 10 cycles.
- **Simultaneous tick and handshake.** With tokens=5, apply `tick`, `aw_hs`, and `aw_len`=7 in the same cycle → next value 5+40−8=37.
- **Override path.** With master 2 at −10 tokens and `aw_pending[2]`=1 → `aw_can_override[2]`=1. Pulse `aw_overrides[2]` → `aw_allow[2]`=1 in the same cycle. A handshake with `len`=15 then gives −26.
- **Low saturation and period change.** Using `TOKEN_WIDTH`=12, repeated `len`=255 bursts clamp the counter at −2048. Changing `refill_period` from 1000 to 5 at count 500 → a tick on the next cycle, then every 5 cycles.
